// File: rtl/io_pkg.sv
// Shared constants and helpers for the memory-mapped front-panel controller:
// register map and the active-low hex-to-seven-segment decode.
package io_pkg;

  localparam logic [1:0] ADDR_DISP  = 2'd0;
  localparam logic [1:0] ADDR_BLANK = 2'd1;
  localparam logic [1:0] ADDR_LEVEL = 2'd2;
  localparam logic [1:0] ADDR_EVENT = 2'd3;

  // Returns {g, f, e, d, c, b, a}; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_ctrl_if.sv
// CPU data-memory bus slice seen by the I/O controller: register select,
// write strobe and data, plus the combinational read-back.
interface io_ctrl_if #(
  parameter int DW = 18
) ();
  logic [1:0]    addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stability counter and debounced
// level; rise_o pulses in the cycle whose edge raises the level.
module btn_debounce #(
  parameter int DEB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves a value held (no latch).
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = '0;
    level_d = level_q;
    rise_o  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_o  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped front panel: debounced buttons with latched press events and
// a DIGITS-wide multiplexed seven-segment display driven from CPU registers.
module io_ctrl
  import io_pkg::*;
#(
  parameter int DW          = 18,
  parameter int DIGITS      = 4,
  parameter int BTNS        = 5,
  parameter int DEB_CYCLES  = 8,
  parameter int SCAN_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  io_ctrl_if.slave          bus,
  input  logic [BTNS-1:0]   btn,
  output logic [DIGITS+7:0] seg,
  output logic              evt
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [2*DIGITS-1:0] blank_q, blank_d;
  logic [BTNS-1:0]     event_q, event_d;
  logic [BTNS-1:0]     level, rise, clr;
  logic [SW-1:0]       scan_q, scan_d;
  logic [IW-1:0]       idx_q, idx_d;

  for (genvar i = 0; i < BTNS; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  always_comb begin
    disp_d  = disp_q;
    blank_d = blank_q;
    clr     = '0;
    if (bus.we) begin
      case (bus.addr)
        ADDR_DISP:  disp_d  = bus.wdata[4*DIGITS-1:0];
        ADDR_BLANK: blank_d = bus.wdata[2*DIGITS-1:0];
        ADDR_EVENT: clr     = bus.wdata[BTNS-1:0];
        default:    ;
      endcase
    end
    // A rise in the same cycle as a clear wins, so no press is lost.
    event_d = (event_q & ~clr) | rise;
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= '0;
      blank_q <= {{DIGITS{1'b0}}, {DIGITS{1'b1}}};
      event_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
    end else begin
      disp_q  <= disp_d;
      blank_q <= blank_d;
      event_q <= event_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_DISP:  bus.rdata = DW'(disp_q);
      ADDR_BLANK: bus.rdata = DW'(blank_q);
      ADDR_LEVEL: bus.rdata = DW'(level);
      default:    bus.rdata = DW'(event_q);
    endcase
  end

  logic [3:0]        nibble;
  logic [6:0]        cath;
  logic [DIGITS-1:0] anodes;
  logic              dp_en;

  always_comb begin
    nibble = disp_q[4*int'(idx_q) +: 4];
    dp_en  = blank_q[DIGITS + int'(idx_q)];
    cath   = blank_q[int'(idx_q)] ? 7'h7F : hex_to_seg(nibble);
    anodes = ~(DIGITS'(1) << idx_q);
    // Reset darkens the panel immediately, without waiting for a clock edge.
    seg    = rst ? '1 : {anodes, ~dp_en, cath};
  end

  assign evt = |event_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: a default 4-digit instance and an 8-digit/3-button/32-bit
// instance run in lockstep against a behavioural model of the register map.
module tb_io_ctrl;

  localparam int DIG [2] = '{4, 8};
  localparam int BTN [2] = '{5, 3};
  localparam int DEB [2] = '{8, 3};
  localparam int SCN [2] = '{256, 4};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  addr_v  [2];
  logic        we_v    [2];
  logic [63:0] wdata_v [2];
  logic [7:0]  btn_v   [2];

  io_ctrl_if #(.DW(18)) bus_a ();
  io_ctrl_if #(.DW(32)) bus_b ();
  logic [4:0]  btn_a;
  logic [2:0]  btn_b;
  logic [11:0] seg_a;
  logic [15:0] seg_b;
  logic        evt_a, evt_b;

  assign bus_a.addr  = addr_v[0];
  assign bus_a.we    = we_v[0];
  assign bus_a.wdata = wdata_v[0][17:0];
  assign btn_a       = btn_v[0][4:0];
  assign bus_b.addr  = addr_v[1];
  assign bus_b.we    = we_v[1];
  assign bus_b.wdata = wdata_v[1][31:0];
  assign btn_b       = btn_v[1][2:0];

  io_ctrl #(.DW(18), .DIGITS(4), .BTNS(5), .DEB_CYCLES(8), .SCAN_CYCLES(256)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .btn(btn_a), .seg(seg_a), .evt(evt_a)
  );
  io_ctrl #(.DW(32), .DIGITS(8), .BTNS(3), .DEB_CYCLES(3), .SCAN_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .btn(btn_b), .seg(seg_b), .evt(evt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Lit segments of each hex glyph, by segment letter.
  string SEG_LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    string      s;
    logic [6:0] r;
    s = SEG_LIT[n];
    r = 7'h7F;
    for (int j = 0; j < s.len(); j++) r[int'(s[j]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic logic [63:0] lowmask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  // Model: register contents, debounced levels, events, raw-sample history, cycles since reset.
  logic [63:0] m_disp  [2];
  logic [63:0] m_blank [2];
  logic [7:0]  m_level [2];
  logic [7:0]  m_ev    [2];
  logic [7:0]  m_raw   [2][16];
  int          m_t     [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_disp[i]  = '0;
      m_blank[i] = lowmask(DIG[i]);
      m_level[i] = '0;
      m_ev[i]    = '0;
      m_t[i]     = 0;
      for (int j = 0; j < 16; j++) m_raw[i][j] = '0;
    end
  endtask

  // A level flips once the synchronised input (raw two edges back) has
  // differed from it for DEB consecutive edges.
  task automatic model_edge(input int i);
    logic [7:0]  rise;
    logic [63:0] clr;
    bit          moved;
    for (int j = 15; j > 0; j--) m_raw[i][j] = m_raw[i][j-1];
    m_raw[i][0] = btn_v[i];
    rise = '0;
    for (int b = 0; b < BTN[i]; b++) begin
      moved = 1'b1;
      for (int j = 2; j <= DEB[i] + 1; j++)
        if (m_raw[i][j][b] == m_level[i][b]) moved = 1'b0;
      if (moved) begin
        m_level[i][b] = ~m_level[i][b];
        rise[b]       = m_level[i][b];
      end
    end
    clr = (we_v[i] && addr_v[i] == 2'd3) ? (wdata_v[i] & lowmask(BTN[i])) : '0;
    m_ev[i] = (m_ev[i] & ~clr[7:0]) | rise;
    if (we_v[i] && addr_v[i] == 2'd0) m_disp[i]  = wdata_v[i] & lowmask(4 * DIG[i]);
    if (we_v[i] && addr_v[i] == 2'd1) m_blank[i] = wdata_v[i] & lowmask(2 * DIG[i]);
    m_t[i]++;
  endtask

  function automatic logic [63:0] exp_rd(input int i);
    case (addr_v[i])
      2'd0:    return m_disp[i];
      2'd1:    return m_blank[i];
      2'd2:    return 64'(m_level[i]);
      default: return 64'(m_ev[i]);
    endcase
  endfunction

  function automatic logic [63:0] exp_seg(input int i);
    int          idx;
    logic [63:0] sh, an;
    logic [6:0]  cath;
    logic        dp;
    idx  = (m_t[i] / SCN[i]) % DIG[i];
    sh   = m_disp[i] >> (4 * idx);
    cath = m_blank[i][idx] ? 7'h7F : seg_of(sh[3:0]);
    dp   = ~m_blank[i][DIG[i] + idx];
    an   = lowmask(DIG[i]) & ~(64'd1 << idx);
    return (an << 8) | (64'(dp) << 7) | 64'(cath);
  endfunction

  function automatic logic [63:0] obs_rd(input int i);
    return (i == 0) ? 64'(bus_a.rdata) : 64'(bus_b.rdata);
  endfunction

  function automatic logic [63:0] obs_seg(input int i);
    return (i == 0) ? 64'(seg_a) : 64'(seg_b);
  endfunction

  function automatic logic obs_evt(input int i);
    return (i == 0) ? evt_a : evt_b;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rdata%0d addr%0d t%0d", i, addr_v[i], m_t[i]), obs_rd(i), exp_rd(i));
      check($sformatf("seg%0d t%0d", i, m_t[i]), obs_seg(i), exp_seg(i));
      check($sformatf("evt%0d t%0d", i, m_t[i]), 64'(obs_evt(i)), 64'(|m_ev[i]));
    end
  endtask

  // Asserted between edges; outputs must clear before any clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      we_v[i] = 1'b0; btn_v[i] = '0; addr_v[i] = 2'd2;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst level%0d", i), obs_rd(i), 64'd0);
      check($sformatf("rst seg%0d", i), obs_seg(i), lowmask(DIG[i] + 8));
      check($sformatf("rst evt%0d", i), 64'(obs_evt(i)), 64'd0);
      addr_v[i] = 2'd3;
    end
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("rst event%0d", i), obs_rd(i), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_a(input logic [1:0] a, input logic [63:0] d);
    addr_v[0] = a; wdata_v[0] = d; we_v[0] = 1'b1;
    tick();
    we_v[0] = 1'b0;
  endtask

  task automatic run_random(input int n);
    repeat (n) begin
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < BTN[i]; b++)
          if ($urandom_range(15, 0) == 0) btn_v[i][b] = ~btn_v[i][b];
        we_v[i]    = ($urandom_range(3, 0) == 0);
        addr_v[i]  = 2'($urandom_range(3, 0));
        wdata_v[i] = {$urandom, $urandom};
      end
      tick();
    end
    for (int i = 0; i < 2; i++) we_v[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = '0; we_v[i] = 1'b0; wdata_v[i] = '0; btn_v[i] = '0;
    end
    model_reset();
    #2;
    apply_reset();

    // Display: "1234", then scan order, frame wrap and blank/dp.
    write_a(2'd0, 64'h1234);
    write_a(2'd1, 64'h0);
    addr_v[0] = 2'd0;
    check("digit0 shows 4", 64'(seg_a), 64'hE99);
    while (m_t[0] < 256) tick();
    check("digit1 shows 3", 64'(seg_a), 64'hDB0);
    while (m_t[0] < 1024) tick();
    check("frame wraps to digit0", 64'(seg_a), 64'hE99);
    write_a(2'd1, 64'h12);
    check("digit0 with dp", 64'(seg_a), 64'hE19);
    while (m_t[0] < 1280) tick();
    check("digit1 blanked", 64'(seg_a), 64'hDFF);

    // Debounce: a DEB-1 glitch is rejected, a held press lands after 2+DEB edges.
    addr_v[0] = 2'd2;
    btn_v[0][2] = 1'b1;
    repeat (7) tick();
    btn_v[0][2] = 1'b0;
    repeat (12) tick();
    check("glitch rejected", 64'(bus_a.rdata), 64'h0);
    btn_v[0][2] = 1'b1;
    repeat (9) tick();
    check("level before latency", 64'(bus_a.rdata), 64'h0);
    check("evt before latency", 64'(evt_a), 64'h0);
    tick();
    check("level at latency", 64'(bus_a.rdata), 64'h4);
    check("evt at latency", 64'(evt_a), 64'h1);
    addr_v[0] = 2'd3;
    #1;
    check("event at latency", 64'(bus_a.rdata), 64'h4);

    // Clear racing a new rise keeps the bit; a later clear empties it.
    btn_v[0][2] = 1'b0;
    repeat (12) tick();
    btn_v[0][2] = 1'b1;
    repeat (9) tick();
    write_a(2'd3, 64'h4);
    check("race keeps event", 64'(bus_a.rdata), 64'h4);
    repeat (3) tick();
    write_a(2'd3, 64'h4);
    check("event cleared", 64'(bus_a.rdata), 64'h0);
    check("evt cleared", 64'(evt_a), 64'h0);

    // Wide instance: level read is zero-extended to 32 bits.
    btn_v[1] = 8'h07;
    addr_v[1] = 2'd2;
    repeat (6) tick();
    check("wide level zero-ext", 64'(bus_b.rdata), 64'h7);

    run_random(3000);
    apply_reset();
    run_random(600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Parametrised memory-mapped I/O controller for the puzzle CPU, the successor to the fixed 5-button / 4-digit front panel. Debounces BTNS push-buttons into level and latched press-event registers, and drives a DIGITS-wide multiplexed seven-segment display from CPU-written registers. It sits on the CPU data-memory bus beside the data memory and runs on the divided core clock.

## Interface
- DW, 18, CPU data word width; must be ≥ 4·DIGITS and ≥ BTNS
- DIGITS, 4, number of seven-segment digits scanned
- BTNS, 5, number of button inputs
- DEB_CYCLES, 8, consecutive stable cycles required to accept a button change (≥ 2)
- SCAN_CYCLES, 256, cycles each digit stays lit (≥ 1)

- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  2  register select: 0 DISP, 1 BLANK, 2 BTN_LEVEL, 3 BTN_EVENT
- we  in  1  write strobe, sampled on clk
- wdata  in  DW  write data
- rdata  out  DW  read data, combinational from addr
- btn  in  BTNS  raw asynchronous buttons, active-high
- seg  out  DIGITS+8  {anodes[DIGITS-1:0], dp, g, f, e, d, c, b, a}, all active-low
- evt  out  1  high while any BTN_EVENT bit is set

## Operation
- DISP: DIGITS hex nibbles, digit i = bits [4i+3:4i]. Writes take wdata[4·DIGITS-1:0]; reads zero-extend to DW.
- BLANK: DIGITS bits; bit i set → digit i blank (cathodes all 1). Bits [2·DIGITS-1:DIGITS] are the per-digit dp enables. Writes take the low 2·DIGITS bits.
- BTN_LEVEL: read-only, debounced levels zero-extended. Writes ignored.
- BTN_EVENT: bit i sets on a debounced 0→1 of button i. Writing 1 to bit i clears it; writing 0 has no effect. A set and clear in the same cycle leave the bit set.
- Input path: 2-flop synchroniser per button, then a per-button debouncer. Counter resets to 0 whenever the synchronised input equals the debounced level. Otherwise it increments; at DEB_CYCLES-1 the debounced level takes the new value and the counter resets. Any glitch shorter than DEB_CYCLES is fully rejected.
- Scan: a cycle counter runs 0..SCAN_CYCLES-1 and wraps. On wrap, the digit index advances and wraps from DIGITS-1 to 0. The anode of the current index is 0; all other anodes are 1. Cathodes show hex decode 0-F of the selected nibble, or all 1 if blanked. dp = ~dp-enable of that digit.
- Register and BLANK writes take effect on the displayed digit in the cycle after the write edge. No tearing logic is required.

## Timing
- Reset (async assert, sync-safe deassert handled at top level):
  - DISP = 0
  - BLANK = all-blank, no dp
  - BTN_LEVEL = 0, BTN_EVENT = 0, evt = 0
  - Debouncers and scan counters = 0, digit index = 0
  - seg = all ones
- Reset mid-scan or mid-debounce discards all progress. No event is generated from a level seen during reset.
- Button latency: a raw edge held stable reaches BTN_LEVEL exactly 2 + DEB_CYCLES clk cycles later. BTN_EVENT and evt rise in that same cycle.
- Register writes are visible on rdata the cycle after the write edge. Reads have zero-cycle latency and no side effects.
- Digit dwell is exactly SCAN_CYCLES cycles. A full frame is DIGITS·SCAN_CYCLES cycles.

## Structure
- Package io_pkg holds:
  - address constants ADDR_DISP, ADDR_BLANK, ADDR_LEVEL, ADDR_EVENT
  - the 4→7 hex-to-segment decode function (active-low)
- Sub-module btn_debounce: one instance per button. Contains synchroniser, counter and level register, parametrised by DEB_CYCLES; outputs level and rise pulse.
- The scan counter, register file and segment mux stay in io_ctrl.

## Test plan
- Reset: assert rst mid-operation → seg = all ones, rdata = 0 at addr 2/3, evt = 0, with no clk edge required.
- Debounce: btn[2] goes high for DEB_CYCLES-1 cycles, then low → BTN_LEVEL stays 0. btn[2] held high → BTN_LEVEL = 0x4, BTN_EVENT = 0x4 and evt = 1 exactly 2+DEB_CYCLES cycles after the edge.
- Event clear race: write 0x4 to BTN_EVENT in the same cycle as a new rise on button 2 → bit stays set. A later write 0x4 with no rise → BTN_EVENT = 0, evt = 0.
- Display: write DISP = 0x1234 and BLANK = 0 → digit 0 shows cathodes 0x99 ("4") with anodes 1110 for SCAN_CYCLES cycles, then digit 1 shows "3" (0xB0). The sequence wraps to digit 0 after 4·SCAN_CYCLES cycles.
- Blank/dp: write BLANK = 0x12 (digit 1 blank, dp on digit 0) → digit 0 cathodes 0x19, digit 1 cathodes 0xFF.
- Parameters: DIGITS = 8, BTNS = 3, DW = 32 → 8-digit scan order correct, seg width 16, and a BTN_LEVEL read zero-extends the upper 29 bits.
